// File: rtl/serterm_pkg.sv
// rtl/serterm_pkg.sv - shared serial-terminal constants and receive FSM states
package serterm_pkg;

  localparam int CLK_HZ       = 12_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - valid/ready character channel from receiver to text controller
interface uart_rx_fifo_if;

  logic [7:0] o_char;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_char, output o_valid, input i_ready);
  modport slave  (input o_char, input o_valid, output i_ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-2 depth, head word shown combinationally
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_en;
  logic             pop_en;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign o_full  = count[AW];
  assign o_empty = (count == '0);
  assign pop_en  = i_pop & ~o_empty;
  assign push_en = i_push & (~o_full | pop_en);
  assign o_rdata = mem[rd_ptr];
  assign o_count = count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) mem[wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a character FIFO with RTS flow control
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = serterm_pkg::CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_HIGH     = 12,
  parameter int RTS_LOW      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_rx,
  uart_rx_fifo_if.master char_if,
  output logic           o_rts_n,
  output logic           o_frame_err,
  output logic           o_overrun
);

  import serterm_pkg::*;

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] RTS_HI  = CNTW'(RTS_HIGH);
  localparam logic [CNTW-1:0] RTS_LO  = CNTW'(RTS_LOW);

  rx_state_e       state;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt;
  logic            tick;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push_r;
  logic            frame_err_r;
  logic [7:0]      head;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // START only waits half a bit so later samples land mid-bit
  assign tick = (clk_cnt == ((state == ST_START) ? HALF_TC : BIT_TC));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
      clk_cnt     <= (tick || state == ST_IDLE || state == ST_RECOVER) ? '0 : clk_cnt + 1'b1;
      case (state)
        ST_IDLE: if (!rx_s) state <= ST_START;
        ST_START: if (tick) begin
          bit_idx <= '0;
          state   <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (tick) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= ST_STOP;
        end
        ST_STOP: if (tick) begin
          if (rx_s) begin
            push_r <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            frame_err_r <= 1'b1;
            state       <= ST_RECOVER;
          end
        end
        // a held break must return high before another start edge counts
        ST_RECOVER: if (rx_s) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_r),
    .i_wdata (shreg),
    .i_pop   (char_if.i_ready),
    .o_rdata (head),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  assign char_if.o_char  = head;
  assign char_if.o_valid = ~empty;
  assign o_frame_err     = frame_err_r;
  // when full o_valid is high, so i_ready alone decides whether a slot frees up
  assign o_overrun       = push_r & full & ~char_if.i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)             o_rts_n <= 1'b1;
    else if (count >= RTS_HI) o_rts_n <= 1'b1;
    else if (count <= RTS_LO) o_rts_n <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  localparam int CPB   = 104;
  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_rx = 1'b1;
  logic o_rts_n;
  logic o_frame_err;
  logic o_overrun;

  uart_rx_fifo_if cif();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .RTS_HIGH     (12),
    .RTS_LOW      (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .char_if     (cif.master),
    .o_rts_n     (o_rts_n),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_pop = 0;
  int lat = 992;
  int valid_at = -1;
  bit rand_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_frame_err) n_ferr++;
      if (o_overrun) n_ovr++;
      if (cif.o_valid && cif.i_ready) begin
        n_pop++;
        if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else check("pop_data", {24'd0, cif.o_char}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_ready) cif.i_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // Drive one 8N1 frame; the model takes the byte just before it can appear at the head.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit coincide);
    logic [9:0] bits;
    int bi;
    bits = {stop_ok, b, 1'b0};
    valid_at = -1;
    for (int k = 0; k < 10 * CPB; k++) begin
      bi = k / CPB;
      i_rx = bits[bi[3:0]];
      if (rand_ready) cif.i_ready = 1'($urandom_range(0, 1));
      if (coincide) cif.i_ready = (k == lat - 1);
      if (k == lat - 1 && stop_ok && (exp_q.size() < DEPTH || coincide)) exp_q.push_back(b);
      if (valid_at < 0 && cif.o_valid) valid_at = k;
      step();
    end
    i_rx = 1'b1;
    if (coincide) cif.i_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    cif.i_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      step();
      guard++;
    end
    step();
    check({tag, "_model_empty"}, exp_q.size(), 0);
    check({tag, "_valid_low"}, cif.o_valid, 1'b0);
    cif.i_ready = 1'b0;
  endtask

  initial begin
    int p0;
    int f0;
    int o0;
    logic [9:0] bits;
    int bi;

    cif.i_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rst_valid", cif.o_valid, 1'b0);
      check("rst_rts_n", o_rts_n, 1'b1);
      step();
    end
    i_rst_n = 1'b1;
    step();
    check("rel_rts_n", o_rts_n, 1'b0);
    check("rel_valid", cif.o_valid, 1'b0);
    check("rel_flags", {o_frame_err, o_overrun}, 2'b00);

    cif.i_ready = 1'b1;
    p0 = n_pop;
    send_frame(8'h41, 1'b1, 1'b0);
    check("latency_0x41", (valid_at >= 988 && valid_at <= 996), 1'b1);
    if (valid_at >= 988 && valid_at <= 996) lat = valid_at;
    idle(20);
    check("pops_0x41", n_pop - p0, 1);

    f0 = n_ferr;
    p0 = n_pop;
    i_rx = 1'b0;
    idle(30);
    i_rx = 1'b1;
    idle(200);
    check("glitch_no_push", n_pop - p0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    check("after_glitch_pop", n_pop - p0, 1);

    f0 = n_ferr;
    p0 = n_pop;
    send_frame(8'h55, 1'b0, 1'b0);
    i_rx = 1'b0;
    idle(3 * CPB);
    i_rx = 1'b1;
    idle(50);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_push", n_pop - p0, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("after_ferr_pop", n_pop - p0, 1);

    cif.i_ready = 1'b0;
    o0 = n_ovr;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      check("rts_fill", o_rts_n, (i + 1) >= 12);
    end
    check("overrun_17th", n_ovr - o0, 1);
    check("full_model", exp_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      cif.i_ready = 1'b1;
      step();
      cif.i_ready = 1'b0;
      step();
      check("rts_drain", o_rts_n, exp_q.size() > 4);
    end
    drain("ovf");

    o0 = n_ovr;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h80 + 8'(i), 1'b1, 1'b0);
    p0 = n_pop;
    send_frame(8'hEE, 1'b1, 1'b1);
    check("coincide_no_ovr", n_ovr - o0, 0);
    check("coincide_one_pop", n_pop - p0, 1);
    check("coincide_still_full", exp_q.size(), DEPTH);
    check("coincide_valid", cif.o_valid, 1'b1);
    drain("coincide");
    check("coincide_total_pops", n_pop - p0, DEPTH + 1);

    for (int i = 0; i < 3; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    bits = {1'b1, 8'hA7, 1'b0};
    for (int k = 0; k < 5 * CPB + 50; k++) begin
      bi = k / CPB;
      i_rx = bits[bi[3:0]];
      step();
    end
    i_rst_n = 1'b0;
    exp_q.delete();
    i_rx = 1'b1;
    step();
    check("midrst_rts_n", o_rts_n, 1'b1);
    idle(2);
    i_rst_n = 1'b1;
    idle(2);
    check("midrst_empty", cif.o_valid, 1'b0);
    idle(20);
    cif.i_ready = 1'b1;
    p0 = n_pop;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("midrst_next_pop", n_pop - p0, 1);

    rand_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      idle($urandom_range(0, 30));
    end
    rand_ready = 1'b0;
    drain("rand");
    check("rand_pops", n_pop - p0, 8);

    check("ferr_total", n_ferr, 1);
    check("ovr_total", n_ovr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
